// File: rtl/div3_sched_if.sv
// Request/response bundle for the two-requester divide-by-3 scheduler.
// The master side is the requesters plus the response consumer; the slave side is div3_sched.
interface div3_sched_if;
    logic       req0_valid;
    logic [6:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_data;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_quot;
    logic [1:0] rsp_rem;
    logic       rsp_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_quot, rsp_rem, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_quot, rsp_rem, rsp_id
    );
endinterface

// File: rtl/div3_sched.sv
// Time-shares one 7-bit divide-by-3 unit between the column and row address generators.
// Define DIV3_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

// One restoring-division step: shift in a dividend bit, subtract 3 if it fits.
module div3_stage (
    input  logic [1:0] rem_i,
    input  logic       bit_i,
    output logic       quot_o,
    output logic [1:0] rem_o
);
    logic [2:0] trial;

    assign trial  = {rem_i, bit_i};
    assign quot_o = (trial >= 3'd3);
    assign rem_o  = quot_o ? 2'(trial - 3'd3) : trial[1:0];
endmodule

// Combinational 7-bit divide by 3; the top dividend bit alone can never reach 3,
// so the chain starts one bit down and yields a 6-bit quotient.
module div3 (
    input  logic [6:0] dividend_i,
    output logic [5:0] quot_o,
    output logic [1:0] rem_o
);
    logic [6:0][1:0] part_rem;

    assign part_rem[6] = {1'b0, dividend_i[6]};

    for (genvar i = 0; i < 6; i++) begin : g_stage
        div3_stage u_stage (
            .rem_i  (part_rem[i+1]),
            .bit_i  (dividend_i[i]),
            .quot_o (quot_o[i]),
            .rem_o  (part_rem[i])
        );
    end

    assign rem_o = part_rem[0];
endmodule

module div3_sched (
    input  logic         clk,
    input  logic         rst,
    div3_sched_if.slave  bus
);
    logic       grant;
    logic       slot_free;
    logic       xfer;
    logic [6:0] div_in;
    logic [5:0] div_quot;
    logic [1:0] chain_rem;
    logic [1:0] calc_rem;

    logic       rsp_valid_q, rsp_valid_d;
    logic [5:0] rsp_quot_q,  rsp_quot_d;
    logic [1:0] rsp_rem_q,   rsp_rem_d;
    logic       rsp_id_q,    rsp_id_d;
`ifdef DIV3_SCHED_RR_EN
    logic       last_q,      last_d;
`endif

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef DIV3_SCHED_RR_EN
            grant = ~last_q;
`else
            grant = 1'b0;
`endif
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign slot_free      = ~rsp_valid_q | bus.rsp_ready;
    assign bus.req0_ready = ~rst & slot_free & ~grant;
    assign bus.req1_ready = ~rst & slot_free &  grant;
    assign xfer           = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

    assign div_in = grant ? bus.req1_data : bus.req0_data;

    div3 u_div3 (
        .dividend_i (div_in),
        .quot_o     (div_quot),
        .rem_o      (chain_rem)
    );

    // Low two bits of data - 2*quot - quot depend only on the low bits of each term.
    assign calc_rem = div_in[1:0] - {div_quot[0], 1'b0} - div_quot[1:0];

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_id_d    = rsp_id_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_quot_d  = div_quot;
            rsp_rem_d   = calc_rem;
            rsp_id_d    = grant;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

`ifdef DIV3_SCHED_RR_EN
    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = grant;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_id_q    <= 1'b0;
`ifdef DIV3_SCHED_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_id_q    <= rsp_id_d;
`ifdef DIV3_SCHED_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_quot  = rsp_quot_q;
    assign bus.rsp_rem   = rsp_rem_q;
    assign bus.rsp_id    = rsp_id_q;

    // The subtractive remainder must agree with the divider chain's own remainder.
    a_rem_consistent: assert property (@(posedge clk) disable iff (rst) xfer |-> (calc_rem == chain_rem));
    a_one_ready:      assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
endmodule

// File: tb/tb_div3_sched.sv
// Randomised and directed bench for div3_sched against a spec-level arbitration/division model.
module tb_div3_sched;
    logic clk = 1'b0;
    logic rst;

    div3_sched_if bus();

    div3_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef DIV3_SCHED_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // requester / consumer stimulus state
    bit       p0, p1;
    bit [6:0] pd0, pd1;
    bit       cons_rdy;
    bit       rst_drv;

    // reference model
    bit       m_valid;
    bit [5:0] m_quot;
    bit [1:0] m_rem;
    bit       m_id;
    bit       m_last;
    bit       e_r0, e_r1;
    bit       xf0, xf1;

    function automatic bit winner(bit v0, bit v1, bit last);
        if (v0 && v1) return RR_MODE ? !last : 1'b0;
        return v1 && !v0;
    endfunction

    task automatic setup();
        bit w;
        bit slot;
        @(negedge clk);
        bus.req0_valid = p0;
        bus.req0_data  = pd0;
        bus.req1_valid = p1;
        bus.req1_data  = pd1;
        bus.rsp_ready  = cons_rdy;
        rst            = rst_drv;
        #1;
        w    = winner(p0, p1, m_last);
        slot = !m_valid || cons_rdy;
        e_r0 = !rst_drv && slot && !w;
        e_r1 = !rst_drv && slot && w;
        xf0  = e_r0 && p0;
        xf1  = e_r1 && p1;
    endtask

    task automatic clock();
        bit [6:0] d;
        @(posedge clk);
        if (rst_drv) begin
            m_valid = 0; m_quot = 0; m_rem = 0; m_id = 0; m_last = 1;
        end else if (xf0 || xf1) begin
            d       = xf1 ? pd1 : pd0;
            m_quot  = 6'(d / 3);
            m_rem   = 2'(d % 3);
            m_id    = xf1;
            m_valid = 1;
            m_last  = xf1;
        end else if (m_valid && cons_rdy) begin
            m_valid = 0;
        end
        if (xf0) p0 = 0;
        if (xf1) p1 = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_drv = 1; cons_rdy = 1;
        p0 = 1; pd0 = 7'd5; p1 = 1; pd1 = 7'd6;
        repeat (2) begin
            setup();
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
            end
            clock();
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b q=%0d r=%0d id=%b want all 0",
                     bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id);
        end
        rst_drv = 0; p0 = 0; p1 = 0;
        setup(); clock();
    endtask

    task automatic test_exhaustive();
        cons_rdy = 1;
        for (int d = 0; d < 128; d++) begin
            p0 = 1; pd0 = 7'(d);
            setup();
            checks++;
            if (bus.req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL exh_ready d=%0d got %b want 1", d, bus.req0_ready);
            end
            clock();
            checks++;
            if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'(d / 3), 2'(d % 3), 1'b0}) begin
                errors++;
                $display("FAIL exh_rsp d=%0d got v=%b q=%0d r=%0d id=%b want v=1 q=%0d r=%0d id=0",
                         d, bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id, d / 3, d % 3);
            end
            if (d == 127) begin
                checks++;
                if (bus.rsp_quot !== 6'd42 || bus.rsp_rem !== 2'd1) begin
                    errors++;
                    $display("FAIL exh_127 got q=%0d r=%0d want q=42 r=1", bus.rsp_quot, bus.rsp_rem);
                end
            end
        end
        setup(); clock();
    endtask

    task automatic test_contention();
        int i0 = 0;
        int i1 = 0;
        int seq_rr [6] = '{5, 100, 6, 101, 7, 102};
        int seq_fp [6] = '{5, 6, 7, 100, 101, 102};
        int exp_d;
        bit exp_id;
        rst_drv = 1; p0 = 0; p1 = 0; cons_rdy = 1;
        setup(); clock();
        rst_drv = 0;
        for (int k = 0; k < 6; k++) begin
            if (!p0 && i0 < 3) begin p0 = 1; pd0 = 7'(5 + i0); end
            if (!p1 && i1 < 3) begin p1 = 1; pd1 = 7'(100 + i1); end
            setup();
            checks++;
            if (({bus.req1_ready, bus.req0_ready} & {p1, p0}) !== ({e_r1, e_r0} & {p1, p0})) begin
                errors++;
                $display("FAIL cont_ready k=%0d got r1r0=%b%b want %b%b", k, bus.req1_ready, bus.req0_ready, e_r1, e_r0);
            end
            clock();
            if (xf0) i0++;
            if (xf1) i1++;
            exp_d  = RR_MODE ? seq_rr[k] : seq_fp[k];
            exp_id = RR_MODE ? bit'(k % 2) : (k >= 3);
            checks++;
            if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'(exp_d / 3), 2'(exp_d % 3), exp_id}) begin
                errors++;
                $display("FAIL cont_rsp k=%0d got v=%b q=%0d r=%0d id=%b want q=%0d r=%0d id=%b",
                         k, bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id, exp_d / 3, exp_d % 3, exp_id);
            end
        end
        setup(); clock();
    endtask

    task automatic test_backpressure();
        cons_rdy = 1; p0 = 1; pd0 = 7'd9;
        setup(); clock();
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'd3, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_first got v=%b q=%0d r=%0d want v=1 q=3 r=0", bus.rsp_valid, bus.rsp_quot, bus.rsp_rem);
        end
        cons_rdy = 0; p0 = 1; pd0 = 7'd20; p1 = 1; pd1 = 7'd50;
        repeat (4) begin
            setup();
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
            end
            clock();
            checks++;
            if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'd3, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold got v=%b q=%0d r=%0d id=%b want v=1 q=3 r=0 id=0",
                         bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id);
            end
        end
        cons_rdy = 1;
        repeat (3) begin
            setup();
            checks++;
            if (({bus.req1_ready, bus.req0_ready} & {p1, p0}) !== ({e_r1, e_r0} & {p1, p0})) begin
                errors++;
                $display("FAIL bp_release_ready got r1r0=%b%b want %b%b", bus.req1_ready, bus.req0_ready, e_r1, e_r0);
            end
            clock();
            checks++;
            if (bus.rsp_valid !== m_valid ||
                (m_valid && {bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {m_quot, m_rem, m_id})) begin
                errors++;
                $display("FAIL bp_release_rsp got v=%b q=%0d r=%0d id=%b want v=%b q=%0d r=%0d id=%b",
                         bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id, m_valid, m_quot, m_rem, m_id);
            end
        end
    endtask

    task automatic test_reset_midstream();
        cons_rdy = 0; p0 = 1; pd0 = 7'd30; p1 = 0;
        setup(); clock();
        p1 = 1; pd1 = 7'd77;
        setup();
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstm_stall got r1=%b want 0", bus.req1_ready);
        end
        clock();
        rst_drv = 1;
        setup();
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstm_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
        end
        clock();
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== 10'd0) begin
            errors++;
            $display("FAIL rstm_outputs got v=%b q=%0d r=%0d id=%b want all 0",
                     bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id);
        end
        rst_drv = 0; cons_rdy = 1; p0 = 1; pd0 = 7'd31;
        setup();
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstm_first_grant got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        clock();
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'd10, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL rstm_first_rsp got v=%b q=%0d r=%0d id=%b want v=1 q=10 r=1 id=0",
                     bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id);
        end
        setup(); clock();
        setup(); clock();
    endtask

    task automatic test_drain_refill();
        cons_rdy = 1; p0 = 1; pd0 = 7'd40; p1 = 0;
        setup(); clock();
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem} !== {1'b1, 6'd13, 2'd1}) begin
            errors++;
            $display("FAIL dr_first got v=%b q=%0d r=%0d want v=1 q=13 r=1", bus.rsp_valid, bus.rsp_quot, bus.rsp_rem);
        end
        p0 = 1; pd0 = 7'd41;
        setup();
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL dr_ready got r0=%b want 1", bus.req0_ready);
        end
        clock();
        checks++;
        if ({bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {1'b1, 6'd13, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL dr_refill got v=%b q=%0d r=%0d id=%b want v=1 q=13 r=2 id=0",
                     bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id);
        end
        setup(); clock();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dr_drain got v=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!p0 && ($urandom % 3 != 0)) begin p0 = 1; pd0 = 7'($urandom); end
            if (!p1 && ($urandom % 3 != 0)) begin p1 = 1; pd1 = 7'($urandom); end
            cons_rdy = ($urandom % 4 != 0);
            rst_drv  = ($urandom % 64 == 0);
            setup();
            checks++;
            if (({bus.req1_ready, bus.req0_ready} & {p1, p0}) !== ({e_r1, e_r0} & {p1, p0})) begin
                errors++;
                $display("FAIL rand_ready c=%0d got r1r0=%b%b want %b%b", c, bus.req1_ready, bus.req0_ready, e_r1, e_r0);
            end
            clock();
            checks++;
            if (bus.rsp_valid !== m_valid ||
                (m_valid && {bus.rsp_quot, bus.rsp_rem, bus.rsp_id} !== {m_quot, m_rem, m_id})) begin
                errors++;
                $display("FAIL rand_rsp c=%0d got v=%b q=%0d r=%0d id=%b want v=%b q=%0d r=%0d id=%b",
                         c, bus.rsp_valid, bus.rsp_quot, bus.rsp_rem, bus.rsp_id, m_valid, m_quot, m_rem, m_id);
            end
        end
        rst_drv = 0;
    endtask

    initial begin
        p0 = 0; p1 = 0; pd0 = 0; pd1 = 0; cons_rdy = 1; rst_drv = 1;
        m_valid = 0; m_quot = 0; m_rem = 0; m_id = 0; m_last = 1;
        bus.req0_valid = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_data = 0;
        bus.rsp_ready  = 1;
        rst = 1;
        test_reset();
        test_exhaustive();
        test_contention();
        test_backpressure();
        test_reset_midstream();
        test_drain_refill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
